program_loader: RTL and testbench

Boot-time loader that fills the instruction memory from a byte stream and holds the core in reset until the image is complete and verified. It sits between a serial or host byte source and the program-memory write port, and is the writer side of the memory the fetch path reads through `program_memory[pc>>2]`. Word layout matches the fetch path: word `k` holds the instruction at byte address `4k`, little-endian.

---
 rtl/program_loader.sv | 137 +++++++++++++
 tb/tb_program_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: boot-time loader that fills instruction memory from a byte
// stream and holds the core in reset until the image is loaded and verified.
//
// Frame: CNT_LO, CNT_HI (16-bit word count N, little-endian), 4*N data bytes
// (each word little-endian), then one checksum byte = XOR of all data bytes.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   rx_data    stream byte
//   rx_valid   rx_data is valid
//   rx_ready   loader accepts a byte this cycle (transfer on valid && ready)
//   mem_we     one-cycle program memory write strobe
//   mem_addr   word index being written (held when mem_we = 0)
//   mem_wdata  assembled instruction word (held when mem_we = 0)
//   core_hold  holds the core / PC in reset while 1
//   done       image loaded and checksum good (sticky)
//   error      bad length or bad checksum (sticky)
module program_loader #(
  parameter int PROGRAM_MEMORY_SIZE_WORDS = 64,
  parameter int ADDR_WIDTH                = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] MAX_WORDS = 16'(PROGRAM_MEMORY_SIZE_WORDS);

  state_t                state, state_nxt;
  logic [15:0]           cnt;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            lane;
  logic [23:0]           asm_q;     // bytes 0..2 of the word being assembled
  logic [7:0]            csum;
  logic                  accept;
  logic                  last_byte;
  logic                  last_word;
  logic [15:0]           cnt_rx;

  // Full count as it stands once the high byte arrives.
  assign cnt_rx    = {rx_data, cnt[7:0]};
  assign last_byte = (lane == 2'd3);
  // In S_DATA cnt >= 1, so cnt - 1 cannot wrap.
  assign last_word = (16'(word_idx) == cnt - 16'd1);
  assign accept    = rx_valid && rx_ready;

  assign done      = (state == S_DONE);
  assign error     = (state == S_ERROR);
  assign core_hold = (state != S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_CNT_LO;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    case (state)
      S_CNT_LO: begin
        rx_ready = reset;
        if (accept) state_nxt = S_CNT_HI;
      end
      S_CNT_HI: begin
        rx_ready = reset;
        if (accept) begin
          if (cnt_rx > MAX_WORDS)  state_nxt = S_ERROR;
          else if (cnt_rx == '0)   state_nxt = S_CHECK;
          else                     state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready = reset;
        if (accept && last_byte && last_word) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        rx_ready = reset;
        if (accept) state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
      end
      default: state_nxt = state;  // terminal states: only reset leaves
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      word_idx  <= '0;
      lane      <= '0;
      asm_q     <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_CNT_LO: cnt[7:0]  <= rx_data;
          S_CNT_HI: cnt[15:8] <= rx_data;
          S_DATA: begin
            csum <= csum ^ rx_data;
            lane <= lane + 2'd1;  // wraps to 0 after the 4th byte
            if (last_byte) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_idx;
              mem_wdata <= {rx_data, asm_q};
              // Stop at N-1 so the index never leaves the memory range.
              if (!last_word) word_idx <= word_idx + 1'b1;
            end else begin
              asm_q[{lane, 3'b000} +: 8] <= rx_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: expected memory writes go into a
// scoreboard queue as frames are driven; a negedge monitor pops and compares
// every mem_we pulse.
module tb_program_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        done;
  logic        error;

  int  checks = 0;
  int  errors = 0;
  wr_t sb[$];
  logic prev_we = 1'b0;

  program_loader #(.PROGRAM_MEMORY_SIZE_WORDS(64), .ADDR_WIDTH(6)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every write pulse must match the next expected write
  // and must not follow another pulse on the previous cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      check("we_single_cycle", 32'(prev_we), 32'd0);
      check("we_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        wr_t e;
        e = sb.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", mem_wdata, e.data);
      end
    end
    prev_we = (mem_we === 1'b1);
  end

  task automatic push_two();
    sb.push_back('{addr: 6'd0, data: 32'h0010_0513});
    sb.push_back('{addr: 6'd1, data: 32'h0020_0593});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    check("rst_rx_ready",  32'(rx_ready),  32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", mem_wdata,      32'd0);
    check("rst_core_hold", 32'(core_hold), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_error",     32'(error),     32'd0);
    reset = 1'b1;
    #1;
    check("rst_rx_ready_rise", 32'(rx_ready), 32'd1);
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (rx_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_frame(input byte_q_t bytes, input int maxgap);
    foreach (bytes[i]) send_byte(bytes[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic check_end(input string tag, input logic d, input logic e);
    check({tag, "_done"},      32'(done),      32'(d));
    check({tag, "_error"},     32'(error),     32'(e));
    check({tag, "_core_hold"}, 32'(core_hold), 32'(!d));
    check({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    check({tag, "_sb_empty"},  32'(sb.size()), 32'd0);
  endtask

  byte_q_t two_good, two_bad;

  initial begin
    two_good = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    two_bad  = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00, 8'hB1};

    // 1: two-word load, continuous rx_valid
    do_reset();
    push_two();
    send_frame(two_good, 0);
    check_end("t1", 1'b1, 1'b0);
    check("t1_addr_hold",  32'(mem_addr), 32'd1);
    check("t1_wdata_hold", mem_wdata,     32'h0020_0593);
    repeat (3) @(negedge clk);
    check("t1_done_sticky", 32'(done), 32'd1);

    // 2: same frame with random gaps
    do_reset();
    push_two();
    send_frame(two_good, 5);
    repeat (3) @(negedge clk);
    check_end("t2", 1'b1, 1'b0);

    // 3: zero count, good and bad checksum
    do_reset();
    send_frame('{8'h00, 8'h00, 8'h00}, 0);
    check_end("t3a", 1'b1, 1'b0);
    do_reset();
    send_frame('{8'h00, 8'h00, 8'h01}, 0);
    check_end("t3b", 1'b0, 1'b1);

    // 4: oversize count 65; further bytes must not be taken
    do_reset();
    send_frame('{8'h41, 8'h00}, 0);
    check_end("t4", 1'b0, 1'b1);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("t4_no_accept", 32'(rx_ready), 32'd0);
    check("t4_err_sticky", 32'(error), 32'd1);
    rx_valid = 1'b0;

    // 5: bad checksum after both writes
    do_reset();
    push_two();
    send_frame(two_bad, 0);
    check_end("t5", 1'b0, 1'b1);

    // 6: reset after 6 data bytes (one word written), then full reload
    do_reset();
    sb.push_back('{addr: 6'd0, data: 32'h0010_0513});
    send_frame('{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05}, 0);
    check("t6_partial_sb", 32'(sb.size()), 32'd0);
    check("t6_hold_mid", 32'(core_hold), 32'd1);
    do_reset();
    push_two();
    send_frame(two_good, 0);
    check_end("t6", 1'b1, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
